// File: rtl/fll_trunc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fll_trunc_pkg
// Description : Shared constants, index type and clamp helper for the FLL
//               discriminator truncation scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package fll_trunc_pkg;

  localparam int IDX_MIN = 14;  // lowest truncation index
  localparam int IDX_MAX = 17;  // highest truncation index
  localparam int IN_W    = 19;  // discriminator sample width (signed)
  localparam int OUT_W   = 15;  // truncated sample width (signed)

  typedef logic [4:0] idx_t;

  // Force an arbitrary 5-bit index into the legal window IDX_MIN..IDX_MAX.
  function automatic idx_t clamp_idx(input idx_t v);
    if (v < idx_t'(IDX_MIN)) return idx_t'(IDX_MIN);
    if (v > idx_t'(IDX_MAX)) return idx_t'(IDX_MAX);
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fll_trunc_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : fll_trunc_sched_if
// Description : Bus bundle for fll_trunc_sched: channel request/ack/data,
//               configuration write port and the result stream.
//               master : channel side / configuration host / result sink
//               slave  : the scheduler
// Revision    : 1.0 - initial release
// ============================================================================
interface fll_trunc_sched_if #(
  parameter int NUM_CHAN = 4,
  parameter int CHAN_W   = 2
);
  import fll_trunc_pkg::*;

  logic [NUM_CHAN-1:0]      req;        // per-channel request
  logic [NUM_CHAN*IN_W-1:0] data;       // channel i at [19*i+18:19*i]
  logic [NUM_CHAN-1:0]      ack;        // one-cycle grant pulse
  logic                     auto_en;    // enable auto-ranging
  logic                     cfg_we;     // index write strobe
  logic [CHAN_W-1:0]        cfg_chan;   // target channel of cfg_we
  idx_t                     cfg_index;  // index value to write
  logic                     out_valid;  // result strobe
  logic [CHAN_W-1:0]        out_chan;   // channel of result
  logic [OUT_W-1:0]         out_data;   // truncated sample
  idx_t                     out_index;  // index used for out_data
  logic                     out_ovf;    // sample exceeded window

  modport master (
    output req, data, auto_en, cfg_we, cfg_chan, cfg_index,
    input  ack, out_valid, out_chan, out_data, out_index, out_ovf
  );

  modport slave (
    input  req, data, auto_en, cfg_we, cfg_chan, cfg_index,
    output ack, out_valid, out_chan, out_data, out_index, out_ovf
  );

endinterface
`default_nettype wire

// File: rtl/fll_trunc_window.sv
`default_nettype none
// ============================================================================
// Module      : fll_trunc_window
// Description : Combinational truncation window. For index k the kept
//               magnitude bits are x[k-1:k-14] under the sign bit x[18];
//               x[17:k] are the bits that must be pure sign extension.
//               Optional build macro FLL_TRUNC_SAT_EN: saturate on overflow
//               instead of wrapping.
// Ports       : i_x    - 19-bit signed sample
//               i_k    - truncation index (clamped to 14..17 internally)
//               o_data - 15-bit truncated sample
//               o_ovf  - x[17:k] not all equal to the sign
//               o_head - x[k:k-1] both equal to the sign
// Revision    : 1.0 - initial release
// ============================================================================
module fll_trunc_window
  import fll_trunc_pkg::*;
(
  input  logic [IN_W-1:0]  i_x,
  input  idx_t             i_k,
  output logic [OUT_W-1:0] o_data,
  output logic             o_ovf,
  output logic             o_head
);

  logic        w_s;
  idx_t        w_k;
  logic [13:0] w_mag;

  assign w_s = i_x[IN_W-1];
  assign w_k = clamp_idx(i_k);

  always_comb begin
    w_mag  = i_x[16:3];
    o_ovf  = (i_x[17] != w_s);
    o_head = (i_x[17] == w_s) && (i_x[16] == w_s);
    case (w_k)
      5'd14: begin
        w_mag  = i_x[13:0];
        o_ovf  = (i_x[17:14] != {4{w_s}});
        o_head = (i_x[14] == w_s) && (i_x[13] == w_s);
      end
      5'd15: begin
        w_mag  = i_x[14:1];
        o_ovf  = (i_x[17:15] != {3{w_s}});
        o_head = (i_x[15] == w_s) && (i_x[14] == w_s);
      end
      5'd16: begin
        w_mag  = i_x[15:2];
        o_ovf  = (i_x[17:16] != {2{w_s}});
        o_head = (i_x[16] == w_s) && (i_x[15] == w_s);
      end
      default: begin
        w_mag  = i_x[16:3];
        o_ovf  = (i_x[17] != w_s);
        o_head = (i_x[17] == w_s) && (i_x[16] == w_s);
      end
    endcase
  end

`ifdef FLL_TRUNC_SAT_EN
  // Clip to the most positive / most negative 15-bit code on overflow.
  assign o_data = o_ovf ? (w_s ? 15'h4000 : 15'h3FFF) : {w_s, w_mag};
`else
  assign o_data = {w_s, w_mag};
`endif

endmodule
`default_nettype wire

// File: rtl/fll_trunc_sched.sv
`default_nettype none
// ============================================================================
// Module      : fll_trunc_sched
// Description : Shares one truncation window among NUM_CHAN FLL channels.
//               Round-robin grant (one per cycle), per-channel truncation
//               index 14..17 auto-ranged from overflow/headroom, registered
//               result stream one cycle after the grant.
//               Optional build macro FLL_TRUNC_SAT_EN (see fll_trunc_window).
// Ports       : clk     - system clock
//               reset_n - asynchronous active-low reset
//               bus     - fll_trunc_sched_if.slave (req/data/ack, cfg, out_*)
// Revision    : 1.0 - initial release
// ============================================================================
module fll_trunc_sched
  import fll_trunc_pkg::*;
#(
  parameter int NUM_CHAN    = 4,
  parameter int CHAN_W      = 2,
  parameter int UNDER_COUNT = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  fll_trunc_sched_if.slave bus
);

  logic [CHAN_W-1:0]   r_ptr;
  logic [NUM_CHAN-1:0] r_ack_d;
  idx_t                r_idx [NUM_CHAN];
  logic [7:0]          r_cnt [NUM_CHAN];

  logic                r_out_valid;
  logic [CHAN_W-1:0]   r_out_chan;
  logic [OUT_W-1:0]    r_out_data;
  idx_t                r_out_index;
  logic                r_out_ovf;

  logic [NUM_CHAN-1:0] w_elig;
  logic                w_found;
  logic [CHAN_W-1:0]   w_win;
  int                  w_cand;
  logic [NUM_CHAN-1:0] w_grant;
  logic [CHAN_W-1:0]   w_ptr_nxt;
  logic [IN_W-1:0]     w_x;
  idx_t                w_k;
  logic [OUT_W-1:0]    w_tdata;
  logic                w_ovf;
  logic                w_head;

  // A channel's req in the cycle right after its ack may still be the
  // sample just consumed, so it is not eligible that cycle.
  assign w_elig = bus.req & ~r_ack_d;

  // First eligible request at or after the round-robin pointer.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = 0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      w_cand = (int'(r_ptr) + i) % NUM_CHAN;
      if (!w_found && w_elig[w_cand]) begin
        w_found = 1'b1;
        w_win   = CHAN_W'(w_cand);
      end
    end
  end

  assign w_grant   = w_found ? (NUM_CHAN'(1) << w_win) : '0;
  assign w_ptr_nxt = (w_win == CHAN_W'(NUM_CHAN - 1)) ? '0 : CHAN_W'(w_win + 1'b1);

  // The grant is combinational; hold it off while reset is asserted.
  assign bus.ack = reset_n ? w_grant : '0;

  // Select the winner's sample and current index.
  always_comb begin
    w_x = bus.data[IN_W-1:0];
    w_k = r_idx[0];
    for (int i = 0; i < NUM_CHAN; i++) begin
      if (w_win == CHAN_W'(i)) begin
        w_x = bus.data[i*IN_W +: IN_W];
        w_k = r_idx[i];
      end
    end
  end

  fll_trunc_window u_window (
    .i_x    (w_x),
    .i_k    (w_k),
    .o_data (w_tdata),
    .o_ovf  (w_ovf),
    .o_head (w_head)
  );

  // Arbitration state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr   <= '0;
      r_ack_d <= '0;
    end else begin
      r_ack_d <= w_grant;
      if (w_found) r_ptr <= w_ptr_nxt;
    end
  end

  // Per-channel index and headroom counter. A configuration write is
  // checked first so it overrides a same-cycle auto-range update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CHAN; i++) begin
        r_idx[i] <= idx_t'(IDX_MIN);
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CHAN; i++) begin
        if (bus.cfg_we && (int'(bus.cfg_chan) == i)) begin
          r_idx[i] <= clamp_idx(bus.cfg_index);
          r_cnt[i] <= '0;
        end else if (w_grant[i] && bus.auto_en) begin
          if (w_ovf) begin
            r_idx[i] <= (r_idx[i] >= idx_t'(IDX_MAX)) ? idx_t'(IDX_MAX) : r_idx[i] + 5'd1;
            r_cnt[i] <= '0;
          end else if (w_head) begin
            if (r_cnt[i] == 8'(UNDER_COUNT - 1)) begin
              r_idx[i] <= (r_idx[i] <= idx_t'(IDX_MIN)) ? idx_t'(IDX_MIN) : r_idx[i] - 5'd1;
              r_cnt[i] <= '0;
            end else begin
              r_cnt[i] <= r_cnt[i] + 8'd1;
            end
          end else begin
            r_cnt[i] <= '0;
          end
        end
      end
    end
  end

  // Result stream: reports the index in force at grant time.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_out_chan  <= '0;
      r_out_data  <= '0;
      r_out_index <= idx_t'(IDX_MIN);
      r_out_ovf   <= 1'b0;
    end else begin
      r_out_valid <= w_found;
      if (w_found) begin
        r_out_chan  <= w_win;
        r_out_data  <= w_tdata;
        r_out_index <= clamp_idx(w_k);
        r_out_ovf   <= w_ovf;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_chan  = r_out_chan;
  assign bus.out_data  = r_out_data;
  assign bus.out_index = r_out_index;
  assign bus.out_ovf   = r_out_ovf;

endmodule
`default_nettype wire
